// File: rtl/neuron_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac_seq
// Purpose  : Sequential neuron, act(sum(data_in[i]*weights[i]) + bias).
//            LANES products are accumulated per cycle. The block has a
//            start/valid/ready handshake, an operand snapshot, a runtime
//            activation select, output scaling and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_mac_seq #(
    parameter int NUM_INPUTS = 10,
    parameter int LANES      = 1,
    parameter int DATA_W     = 16,
    parameter int WEIGHT_W   = 16,
    parameter int BIAS_W     = 16,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 24,
    parameter int SHIFT      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [1:0]                     act_mode,
    input  logic [NUM_INPUTS*DATA_W-1:0]   data_in,
    input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights,
    input  logic [BIAS_W-1:0]              bias,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_W-1:0]               data_out,
    output logic                           overflow
);

    localparam int STEPS  = (NUM_INPUTS + LANES - 1) / LANES;
    localparam int PAD_N  = STEPS * LANES;
    localparam int CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PROD_W = DATA_W + WEIGHT_W;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // Clamp limits of the signed output range, expressed at accumulator width
    localparam logic signed [ACC_W-1:0] C_OUT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_OUT_MIN =
        {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_ACT   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                         state_q;
    logic [CNT_W-1:0]               cnt_q;
    logic signed [ACC_W-1:0]        acc_q;
    logic [PAD_N*DATA_W-1:0]        data_q;
    logic [PAD_N*WEIGHT_W-1:0]      weights_q;
    logic [1:0]                     mode_q;
    logic                           busy_q;
    logic                           out_valid_q;
    logic [OUT_W-1:0]               data_out_q;
    logic                           overflow_q;

    logic [PAD_N*DATA_W-1:0]        data_pad;
    logic [PAD_N*WEIGHT_W-1:0]      weights_pad;
    logic signed [PROD_W-1:0]       prod [LANES];
    logic signed [ACC_W-1:0]        lane_sum;
    logic signed [ACC_W-1:0]        acc_d;
    logic signed [ACC_W-1:0]        shifted;
    logic signed [ACC_W-1:0]        act_val;
    logic [OUT_W-1:0]               data_out_d;
    logic                           overflow_d;
    logic                           accept;

    // The snapshot is padded with zero operands up to a whole number of lane
    // groups, so lanes past NUM_INPUTS in the last group multiply 0*0.
    generate
        if (PAD_N > NUM_INPUTS) begin : g_pad
            assign data_pad    = {{((PAD_N - NUM_INPUTS) * DATA_W){1'b0}}, data_in};
            assign weights_pad = {{((PAD_N - NUM_INPUTS) * WEIGHT_W){1'b0}}, weights};
        end else begin : g_nopad
            assign data_pad    = data_in;
            assign weights_pad = weights;
        end
    endgenerate

    // One full-width signed product per lane for the current operand group
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            int idx;
            assign idx     = int'(cnt_q) * LANES + k;
            assign prod[k] = PROD_W'($signed(data_q[idx*DATA_W +: DATA_W]))
                           * PROD_W'($signed(weights_q[idx*WEIGHT_W +: WEIGHT_W]));
        end
    endgenerate

    // Sum the lane products, sign-extended to accumulator width
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + ACC_W'(prod[k]);
        end
        acc_d = acc_q + lane_sum;
    end

    // Scale, activate and saturate the finished accumulator
    always_comb begin
        shifted = acc_q >>> SHIFT;
        case (mode_q)
            2'd1:    act_val = shifted[ACC_W-1] ? '0 : shifted;
            2'd2:    act_val = shifted[ACC_W-1] ? (shifted >>> 3) : shifted;
            default: act_val = shifted;
        endcase
        overflow_d = 1'b0;
        data_out_d = act_val[OUT_W-1:0];
        if (act_val > C_OUT_MAX) begin
            data_out_d = C_OUT_MAX[OUT_W-1:0];
            overflow_d = 1'b1;
        end else if (act_val < C_OUT_MIN) begin
            data_out_d = C_OUT_MIN[OUT_W-1:0];
            overflow_d = 1'b1;
        end
    end

    // A job is taken from IDLE, or from DONE on the same edge as the handoff
    assign accept = start & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));

    // Control FSM with operand snapshot and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            data_q      <= '0;
            weights_q   <= '0;
            mode_q      <= 2'd0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // wait for start; the accept path below handles the load
                end
                ST_ACCUM: begin
                    acc_q <= acc_d;
                    if (cnt_q == C_CNT_LAST) begin
                        state_q <= ST_ACT;
                    end else begin
                        cnt_q <= cnt_q + C_CNT_ONE;
                    end
                end
                ST_ACT: begin
                    data_out_q  <= data_out_d;
                    overflow_q  <= overflow_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Later assignments override the IDLE return from DONE
            if (accept) begin
                data_q    <= data_pad;
                weights_q <= weights_pad;
                mode_q    <= act_mode;
                acc_q     <= ACC_W'($signed(bias));
                cnt_q     <= '0;
                busy_q    <= 1'b1;
                state_q   <= ST_ACCUM;
            end
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_mac_seq
// Purpose  : Scoreboard bench for neuron_mac_seq over four parameter sets
//            (LANES=1, LANES=3, LANES=10 with SHIFT=2, OUT_W=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_mac_seq;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int WW = 16;
    localparam int BW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      start_v;
    logic [1:0]      act_mode;
    logic [N*DW-1:0] data_in;
    logic [N*WW-1:0] weights;
    logic [BW-1:0]   bias;
    logic            out_ready;
    logic [3:0]      busy_v;
    logic [3:0]      valid_v;
    logic [3:0]      ovf_v;
    logic [23:0]     dout0;
    logic [23:0]     dout1;
    logic [23:0]     dout2;
    logic [15:0]     dout3;

    always #5 clk = ~clk;

    neuron_mac_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .act_mode(act_mode),
        .data_in(data_in), .weights(weights), .bias(bias), .busy(busy_v[0]),
        .out_valid(valid_v[0]), .out_ready(out_ready), .data_out(dout0), .overflow(ovf_v[0]));

    neuron_mac_seq #(.LANES(3)) u_l3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .act_mode(act_mode),
        .data_in(data_in), .weights(weights), .bias(bias), .busy(busy_v[1]),
        .out_valid(valid_v[1]), .out_ready(out_ready), .data_out(dout1), .overflow(ovf_v[1]));

    neuron_mac_seq #(.LANES(10), .SHIFT(2)) u_l10 (
        .clk(clk), .rst(rst), .start(start_v[2]), .act_mode(act_mode),
        .data_in(data_in), .weights(weights), .bias(bias), .busy(busy_v[2]),
        .out_valid(valid_v[2]), .out_ready(out_ready), .data_out(dout2), .overflow(ovf_v[2]));

    neuron_mac_seq #(.OUT_W(16)) u_o16 (
        .clk(clk), .rst(rst), .start(start_v[3]), .act_mode(act_mode),
        .data_in(data_in), .weights(weights), .bias(bias), .busy(busy_v[3]),
        .out_valid(valid_v[3]), .out_ready(out_ready), .data_out(dout3), .overflow(ovf_v[3]));

    typedef struct {
        int d;
        bit o;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    int n_checks = 0;
    int n_fail   = 0;

    int D1[10] = '{-2, 5, -1, 10, 3, -4, 7, -6, 2, 8};
    int W1[10] = '{3, 2, 8, 10, 1, 2, 4, 3, 5, 2};
    int D3[10] = '{50, 100, 75, 25, 60, 80, 90, 40, 30, 70};
    int W3[10] = '{10, 20, 15, 5, 12, 18, 25, 8, 7, 14};
    int DS[10] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int dout_of(input int k);
        case (k)
            0:       return int'($signed(dout0));
            1:       return int'($signed(dout1));
            2:       return int'($signed(dout2));
            default: return int'($signed(dout3));
        endcase
    endfunction

    task automatic push(input int k, input int d, input bit o);
        exp_t e;
        e.d = d;
        e.o = o;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic mon_pop(input int k);
        exp_t e;
        bit   have = 1'b0;
        case (k)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2:       if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output dut%0d: got data %0d, expected no output", k, dout_of(k));
        end else begin
            check($sformatf("dut%0d_data", k), dout_of(k), e.d);
            check($sformatf("dut%0d_overflow", k), ovf_v[k], e.o);
        end
    endtask

    // Monitor: every handshake pops one expected result from that DUT's queue
    always @(negedge clk) begin
        if (!rst && out_ready) begin
            for (int k = 0; k < 4; k++) begin
                if (valid_v[k]) mon_pop(k);
            end
        end
    end

    task automatic set_vec(input int d[10], input int w[10], input int b, input bit negw);
        for (int i = 0; i < N; i++) begin
            data_in[i*DW +: DW] = DW'(d[i]);
            weights[i*WW +: WW] = WW'(negw ? -w[i] : w[i]);
        end
        bias = BW'(b);
    endtask

    // Issue a one-cycle start; returns just after the accepting edge
    task automatic launch(input int k, input int mode, input int d, input bit o,
                          input bit do_push);
        @(posedge clk);
        #1;
        act_mode   = mode[1:0];
        start_v[k] = 1'b1;
        if (do_push) push(k, d, o);
        @(posedge clk);
        #1;
        start_v = '0;
        check($sformatf("dut%0d_busy_after_accept", k), busy_v[k], 1);
    endtask

    // Count edges until out_valid is seen; returns on that negedge
    task automatic wait_valid(input int k, input int exp_lat, input string name);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = valid_v[k];
        end
        check(name, seen ? n : -1, exp_lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst       = 1'b1;
        start_v   = '0;
        out_ready = 1'b1;
        act_mode  = 2'd0;
        data_in   = '0;
        weights   = '0;
        bias      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy_v[0], 0);
        check("reset_valid", valid_v, 0);
        check("reset_data", dout_of(0), 0);
        check("reset_overflow", ovf_v, 0);
        rst = 1'b0;

        // Mixed signs, ReLU, 11-cycle latency
        set_vec(D1, W1, 5, 1'b0);
        launch(0, 1, 132, 1'b0, 1'b1);
        wait_valid(0, 11, "t1_latency");

        // Negated weights under every activation
        set_vec(D1, W1, 5, 1'b1);
        launch(0, 0, -122, 1'b0, 1'b1);
        wait_valid(0, 11, "t2_identity_latency");
        launch(0, 1, 0, 1'b0, 1'b1);
        wait_valid(0, 11, "t2_relu_latency");
        launch(0, 2, -16, 1'b0, 1'b1);
        wait_valid(0, 11, "t2_leaky_latency");
        launch(0, 3, -122, 1'b0, 1'b1);
        wait_valid(0, 11, "t2_reserved_latency");

        // Multi-lane: partial last group, single step, scaled output
        set_vec(D3, W3, 50, 1'b0);
        launch(1, 0, 9720, 1'b0, 1'b1);
        wait_valid(1, 5, "t3_l3_latency");
        launch(2, 0, 2430, 1'b0, 1'b1);
        wait_valid(2, 2, "t3_l10_latency");
        set_vec(D1, W1, 5, 1'b0);
        launch(1, 1, 132, 1'b0, 1'b1);
        wait_valid(1, 5, "t3_l3_mixed_latency");

        // Saturation at both ends, and an in-range result on the narrow output
        set_vec(DS, DS, 0, 1'b0);
        launch(3, 0, 32767, 1'b1, 1'b1);
        wait_valid(3, 11, "t4_pos_latency");
        launch(0, 0, 8388607, 1'b1, 1'b1);
        wait_valid(0, 11, "t4_pos24_latency");
        set_vec(DS, DS, 0, 1'b1);
        launch(3, 0, -32768, 1'b1, 1'b1);
        wait_valid(3, 11, "t4_neg_latency");
        set_vec(D1, W1, 5, 1'b1);
        launch(3, 0, -122, 1'b0, 1'b1);
        wait_valid(3, 11, "t4_inrange_latency");

        // Snapshot, ignored start, output hold, back-to-back handoff
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        set_vec(D1, W1, 5, 1'b0);
        launch(0, 1, 132, 1'b0, 1'b1);
        data_in    = '1;
        bias       = BW'(1000);
        act_mode   = 2'd0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        wait_valid(0, 10, "t5_latency");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t5_hold_data", dout_of(0), 132);
            check("t5_hold_valid", valid_v[0], 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        set_vec(D1, W1, 5, 1'b1);
        act_mode   = 2'd0;
        start_v[0] = 1'b1;
        push(0, -122, 1'b0);
        @(posedge clk);
        #1;
        start_v = '0;
        check("t5_b2b_busy", busy_v[0], 1);
        check("t5_b2b_valid_low", valid_v[0], 0);
        wait_valid(0, 11, "t5_b2b_latency");

        // Reset mid-operation discards the job
        set_vec(D1, W1, 5, 1'b0);
        launch(0, 1, 132, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", busy_v[0], 0);
        check("t6_rst_valid", valid_v[0], 0);
        check("t6_rst_data", dout_of(0), 0);
        check("t6_rst_overflow", ovf_v[0], 0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid_v[0]) seen = 1'b1;
        end
        check("t6_no_output", seen, 0);
        launch(0, 1, 132, 1'b0, 1'b1);
        wait_valid(0, 11, "t6_fresh_latency");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", q0.size() + q1.size() + q2.size() + q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Parametrised sequential neuron: computes `act(sum(data_in[i]*weights[i]) + bias)` over `NUM_INPUTS` operands, processing `LANES` products per cycle. It replaces the externally-counted single-lane input-layer neuron and drives layer controllers in the MLP datapath. It adds the following on top of that neuron:

- an internal step counter;
- a start/valid/ready handshake;
- an operand snapshot;
- a runtime-selectable activation;
- output scaling and saturation with an overflow flag.

## Interface

**Parameters**

- `NUM_INPUTS`, 10, number of input/weight pairs (≥1)
- `LANES`, 1, multiply-accumulates per cycle (1..`NUM_INPUTS`)
- `DATA_W`, 16, signed input width
- `WEIGHT_W`, 16, signed weight width
- `BIAS_W`, 16, signed bias width
- `ACC_W`, 40, signed accumulator width (≥ `DATA_W`+`WEIGHT_W`+clog2(`NUM_INPUTS`)+1)
- `OUT_W`, 24, signed output width
- `SHIFT`, 0, arithmetic right shift applied to the sum before activation

**Ports**

- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request a new computation.
- `act_mode`, in, 2: 0 identity, 1 ReLU, 2 leaky ReLU, 3 identity (reserved).
- `data_in`, in, `NUM_INPUTS`*`DATA_W`: flat signed inputs, element i at `[i*DATA_W +: DATA_W]`.
- `weights`, in, `NUM_INPUTS`*`WEIGHT_W`: flat signed weights, same packing.
- `bias`, in, `BIAS_W`: signed bias.
- `busy`, out, 1: high whenever the state is not IDLE.
- `out_valid`, out, 1: `data_out` and `overflow` are valid.
- `out_ready`, in, 1: consumer accepts the result.
- `data_out`, out, `OUT_W`: signed result.
- `overflow`, out, 1: result was saturated.

## Operation

- Derived constant: STEPS = ceil(`NUM_INPUTS`/`LANES`). The step counter runs 0..STEPS-1.
- **FSM states:** IDLE, ACCUM, ACT, DONE.
- **IDLE:** when `start`=1 at an edge:
  - latch `data_in`, `weights`, `bias` and `act_mode` into internal registers;
  - set acc to sign-extended `bias`, cnt to 0, and go to ACCUM.
- **Input stability:** after the accepting edge, changes on the inputs have no effect until the next accept.
- **ACCUM:** each edge adds the `LANES` products for indices cnt*`LANES`+k, k=0..`LANES`-1.
  - Lanes with index ≥ `NUM_INPUTS` (final partial group) contribute 0.
  - When cnt=STEPS-1, go to ACT; otherwise cnt increments.
- **Arithmetic:** products are full-width signed (`DATA_W`+`WEIGHT_W`), sign-extended to `ACC_W`. The accumulator does not wrap for legal parameters.
- **ACT:** compute s = acc >>> `SHIFT` (arithmetic shift, floor), then apply the activation:
  - identity: a = s;
  - ReLU: a = (s<0) ? 0 : s;
  - leaky ReLU: a = (s<0) ? s>>>3 : s.
- **Saturation:** a is clamped to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1]. `overflow`=1 if clamping occurred. The results are registered into `data_out`/`overflow`, `out_valid` is set to 1, and the FSM goes to DONE.
- **DONE:** `data_out`, `overflow` and `out_valid` hold until an edge with `out_ready`=1.
  - At that edge `out_valid` drops.
  - If `start`=1 on the same edge, the new job is accepted (the IDLE accept actions apply) and the FSM goes directly to ACCUM; otherwise it goes to IDLE.
- **Ignored start:** `start` in ACCUM or ACT is ignored. No queueing.
- **Output holding:** `data_out` keeps its last value after the handoff until the next ACT.

## Timing

- **Reset values:** `rst`=1 asynchronously forces state IDLE, cnt=0, acc=0, `data_out`=0, `overflow`=0, `out_valid`=0, `busy`=0. All internal operand registers are cleared.
- **Reset mid-operation:** any in-flight computation is discarded and no result is emitted. After release, the block waits in IDLE for `start`.
- **Latency:** with the accepting edge as E0, `out_valid` rises after edge E(STEPS+1).
  - `LANES`=1, `NUM_INPUTS`=10: 11 cycles.
  - `LANES`=3: 5 cycles.
- **`busy`:** rises after E0. It stays high through DONE and falls after the handoff edge unless a new job is accepted on that edge.
- **Throughput:** the start-to-start interval with `out_ready` tied high and `start` held is STEPS+2 cycles.
- **Output stability:** `data_out` is stable for as long as `out_valid`=1.

## Test plan

1. **Mixed signs, `LANES`=1, ReLU.** Stimulus: `data_in` = {-2,5,-1,10,3,-4,7,-6,2,8}, `weights` = {3,2,8,10,1,2,4,3,5,2}, `bias`=5, `act_mode`=1. Required: `data_out`=132 and `overflow`=0, with `out_valid` rising exactly 11 cycles after the accepting edge.
2. **Same vectors as 1 with all weights negated, `bias`=5.** Required outputs:
   - identity: -122;
   - ReLU: 0;
   - leaky: -16.
3. **Large values, `LANES`=3.** Stimulus: `data_in` = {50,100,75,25,60,80,90,40,30,70}, `weights` = {10,20,15,5,12,18,25,8,7,14}, `bias`=50. Required: `data_out`=9720 with latency 5 cycles (partial last group). Repeat with `LANES`=10 (latency 2) and `SHIFT`=2 (result 2430).
4. **Saturation, `OUT_W`=16, identity.** Stimulus: all inputs 32767, weights 32767, `bias` 0. Required: `data_out`=32767, `overflow`=1. With negated weights: -32768, `overflow`=1.
5. **Handshake and snapshot.**
   - Hold `out_ready`=0 for 20 cycles: `data_out` stays stable.
   - Change `data_in` during ACCUM: no effect on the result.
   - Pulse `start` during ACCUM: ignored.
   - `out_ready` and `start` together in DONE: the next result arrives STEPS+1 cycles later with no IDLE cycle.
6. **Reset mid-operation.** Assert `rst` at cycle 4 of test 1 for one cycle: all outputs go to 0 immediately and no `out_valid` follows. A fresh `start` then yields 132.
